// File: rtl/cp0_unit.sv
// Coprocessor-0 for the MEM stage: SR/Cause/EPC, exception and interrupt request, MFC0 read.
// Optional macro CP0_PRID_EN: CP0 register 15 reads PRID_VALUE; without it register 15 reads 0.
module cp0_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req,
  output logic [31:0] HandlerPC
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

`ifdef CP0_PRID_EN
  localparam logic [31:0] PRID_READ = PRID_VALUE;
`else
  // PRID_VALUE stays a parameter in both builds so instantiations need not change.
  localparam logic [31:0] PRID_READ = PRID_VALUE & 32'h0;
`endif

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [31:0] exc_pc;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign int_req = (|(HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
  assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl_q;
  assign req     = int_req | exc_req;
  assign exc_pc  = BDIn ? (VPC - 32'd4) : VPC;

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = HWInt;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (req) begin
      sr_exl_d    = 1'b1;
      cause_exc_d = int_req ? 5'd0 : ExcCodeIn;
      cause_bd_d  = BDIn;
      epc_d       = exc_pc & ~32'd3;
    end else begin
      // Under eret only an SR write still lands, and EXL is cleared after it.
      if (en) begin
        case (CP0Add)
          ADDR_SR: begin
            sr_im_d  = CP0In[15:10];
            sr_exl_d = CP0In[1];
            sr_ie_d  = CP0In[0];
          end
          ADDR_EPC: if (!EXLClr) epc_d = CP0In;
          default: ;
        endcase
      end
      if (EXLClr) sr_exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  assign sr_val    = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
  assign cause_val = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};

  always_comb begin
    CP0Out = '0;
    case (CP0Add)
      ADDR_SR:    CP0Out = sr_val;
      ADDR_CAUSE: CP0Out = cause_val;
      ADDR_EPC:   CP0Out = epc_q;
      ADDR_PRID:  CP0Out = PRID_READ;
      default:    CP0Out = '0;
    endcase
  end

  assign Req       = req;
  assign EPCOut    = epc_q;
  assign HandlerPC = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: expected register values are queued when stimulus is driven
// and popped when the registered result becomes visible.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;
  logic [31:0] HandlerPC;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  cp0_unit #(.HANDLER_ADDR(32'h0000_4180), .PRID_VALUE(32'h5052_4944)) dut (
    .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In), .CP0Out(CP0Out),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .EPCOut(EPCOut), .Req(Req), .HandlerPC(HandlerPC)
  );

  task automatic quiet();
    en = 1'b0; CP0Add = 5'd0; CP0In = '0; VPC = '0; BDIn = 1'b0;
    ExcCodeIn = 5'd0; HWInt = '0; EXLClr = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; quiet();
    cyc(); cyc();
    reset = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    for (int unsigned a = 12; a <= 14; a++) begin
      CP0Add = 5'(a); #1;
      e = exp_q.pop_front(); checks++;
      if (CP0Out !== e) begin errors++; $display("FAIL reset_reg%0d: got %h want %h", a, CP0Out, e); end
    end
    checks++;
    if (Req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", Req); end
    checks++;
    if (EPCOut !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want 0", EPCOut); end
    checks++;
    if (HandlerPC !== 32'h0000_4180) begin errors++; $display("FAIL handler_pc: got %h want 00004180", HandlerPC); end
    @(negedge clk);
  endtask

  task automatic test_exception();
    ExcCodeIn = 5'd4; VPC = 32'h3010; BDIn = 1'b0;
    exp_q.push_back(32'h0000_0010); exp_q.push_back(32'h0000_0002); exp_q.push_back(32'h0000_3010);
    #1; checks++;
    if (Req !== 1'b1) begin errors++; $display("FAIL exc_req: got %b want 1", Req); end
    cyc(); quiet();
    CP0Add = 5'd13; #1; e = exp_q.pop_front(); checks++;
    if (CP0Out !== e) begin errors++; $display("FAIL exc_cause: got %h want %h", CP0Out, e); end
    CP0Add = 5'd12; #1; e = exp_q.pop_front(); checks++;
    if (CP0Out !== e) begin errors++; $display("FAIL exc_sr: got %h want %h", CP0Out, e); end
    e = exp_q.pop_front(); checks++;
    if (EPCOut !== e) begin errors++; $display("FAIL exc_epc: got %h want %h", EPCOut, e); end
    // EXL masks a second exception; IP still tracks the lines.
    ExcCodeIn = 5'd12; VPC = 32'h3014; HWInt = 6'b100000; #1; checks++;
    if (Req !== 1'b0) begin errors++; $display("FAIL exl_mask_req: got %b want 0", Req); end
    exp_q.push_back(32'h0000_8010); exp_q.push_back(32'h0000_3010);
    cyc(); quiet();
    CP0Add = 5'd13; #1; e = exp_q.pop_front(); checks++;
    if (CP0Out !== e) begin errors++; $display("FAIL exl_ip_track: got %h want %h", CP0Out, e); end
    e = exp_q.pop_front(); checks++;
    if (EPCOut !== e) begin errors++; $display("FAIL exl_epc_hold: got %h want %h", EPCOut, e); end
    EXLClr = 1'b1; cyc(); quiet();
  endtask

  task automatic test_delay_slot();
    ExcCodeIn = 5'd12; VPC = 32'h3024; BDIn = 1'b1;
    exp_q.push_back(32'h8000_0030); exp_q.push_back(32'h0000_3020);
    #1; checks++;
    if (Req !== 1'b1) begin errors++; $display("FAIL bd_req: got %b want 1", Req); end
    cyc(); quiet();
    CP0Add = 5'd13; #1; e = exp_q.pop_front(); checks++;
    if (CP0Out !== e) begin errors++; $display("FAIL bd_cause: got %h want %h", CP0Out, e); end
    e = exp_q.pop_front(); checks++;
    if (EPCOut !== e) begin errors++; $display("FAIL bd_epc: got %h want %h", EPCOut, e); end
    EXLClr = 1'b1; cyc(); quiet();
  endtask

  task automatic test_int_vs_exc();
    en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0401;
    exp_q.push_back(32'h0000_0401);
    cyc(); quiet();
    CP0Add = 5'd12; #1; e = exp_q.pop_front(); checks++;
    if (CP0Out !== e) begin errors++; $display("FAIL mtc0_sr: got %h want %h", CP0Out, e); end
    HWInt = 6'b000001; ExcCodeIn = 5'd5; VPC = 32'h3100;
    exp_q.push_back(32'h0000_0400); exp_q.push_back(32'h0000_0403); exp_q.push_back(32'h0000_3100);
    #1; checks++;
    if (Req !== 1'b1) begin errors++; $display("FAIL int_req: got %b want 1", Req); end
    cyc(); quiet();
    CP0Add = 5'd13; #1; e = exp_q.pop_front(); checks++;
    if (CP0Out !== e) begin errors++; $display("FAIL int_cause: got %h want %h", CP0Out, e); end
    CP0Add = 5'd12; #1; e = exp_q.pop_front(); checks++;
    if (CP0Out !== e) begin errors++; $display("FAIL int_sr: got %h want %h", CP0Out, e); end
    e = exp_q.pop_front(); checks++;
    if (EPCOut !== e) begin errors++; $display("FAIL int_epc: got %h want %h", EPCOut, e); end
    EXLClr = 1'b1; cyc(); quiet();
    HWInt = 6'b000010; #1; checks++;
    if (Req !== 1'b0) begin errors++; $display("FAIL masked_int_req: got %b want 0", Req); end
    ExcCodeIn = 5'd5; VPC = 32'h3200;
    exp_q.push_back(32'h0000_0814);
    #1; checks++;
    if (Req !== 1'b1) begin errors++; $display("FAIL masked_exc_req: got %b want 1", Req); end
    cyc(); quiet();
    CP0Add = 5'd13; #1; e = exp_q.pop_front(); checks++;
    if (CP0Out !== e) begin errors++; $display("FAIL masked_exc_cause: got %h want %h", CP0Out, e); end
    EXLClr = 1'b1; cyc(); quiet();
  endtask

  task automatic test_mtc0_suppressed();
    ExcCodeIn = 5'd4; VPC = 32'h3300; en = 1'b1; CP0Add = 5'd14; CP0In = 32'h1234;
    exp_q.push_back(32'h0000_3300);
    cyc(); quiet();
    e = exp_q.pop_front(); checks++;
    if (EPCOut !== e) begin errors++; $display("FAIL req_beats_mtc0: got %h want %h", EPCOut, e); end
    // eret plus an SR write: IM/IE land, EXL ends at 0.
    EXLClr = 1'b1; en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0C03;
    exp_q.push_back(32'h0000_0C01);
    cyc(); quiet();
    CP0Add = 5'd12; #1; e = exp_q.pop_front(); checks++;
    if (CP0Out !== e) begin errors++; $display("FAIL eret_sr: got %h want %h", CP0Out, e); end
    ExcCodeIn = 5'd4; #1; checks++;
    if (Req !== 1'b1) begin errors++; $display("FAIL eret_reenable: got %b want 1", Req); end
    quiet(); @(negedge clk);
  endtask

  task automatic test_mtc0_latency();
    en = 1'b1; CP0Add = 5'd14; CP0In = 32'h0000_1234; #1; checks++;
    if (EPCOut !== 32'h0000_3300) begin errors++; $display("FAIL epc_early: got %h want 00003300", EPCOut); end
    exp_q.push_back(32'h0000_1234);
    cyc(); quiet();
    e = exp_q.pop_front(); checks++;
    if (EPCOut !== e) begin errors++; $display("FAIL epc_write: got %h want %h", EPCOut, e); end
    en = 1'b1; CP0Add = 5'd13; CP0In = 32'hFFFF_FFFF;
    exp_q.push_back(32'h0000_0010);
    cyc(); quiet();
    CP0Add = 5'd13; #1; e = exp_q.pop_front(); checks++;
    if (CP0Out !== e) begin errors++; $display("FAIL cause_readonly: got %h want %h", CP0Out, e); end
    HWInt = 6'b000100; en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_1001; #1; checks++;
    if (Req !== 1'b0) begin errors++; $display("FAIL im_same_cycle: got %b want 0", Req); end
    cyc(); en = 1'b0; #1; checks++;
    if (Req !== 1'b1) begin errors++; $display("FAIL im_next_cycle: got %b want 1", Req); end
    quiet(); @(negedge clk);
  endtask

  task automatic test_reset_wins();
    ExcCodeIn = 5'd4; VPC = 32'h3400; reset = 1'b1; #1; checks++;
    if (Req !== 1'b1) begin errors++; $display("FAIL rw_req: got %b want 1", Req); end
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    cyc(); reset = 1'b0; quiet();
    CP0Add = 5'd12; #1; e = exp_q.pop_front(); checks++;
    if (CP0Out !== e) begin errors++; $display("FAIL rw_sr: got %h want %h", CP0Out, e); end
    CP0Add = 5'd13; #1; e = exp_q.pop_front(); checks++;
    if (CP0Out !== e) begin errors++; $display("FAIL rw_cause: got %h want %h", CP0Out, e); end
    e = exp_q.pop_front(); checks++;
    if (EPCOut !== e) begin errors++; $display("FAIL rw_epc: got %h want %h", EPCOut, e); end
    @(negedge clk);
  endtask

  task automatic test_epc_boundaries();
    ExcCodeIn = 5'd4; VPC = 32'h0; BDIn = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h8000_0010);
    cyc(); quiet();
    e = exp_q.pop_front(); checks++;
    if (EPCOut !== e) begin errors++; $display("FAIL epc_wrap: got %h want %h", EPCOut, e); end
    CP0Add = 5'd13; #1; e = exp_q.pop_front(); checks++;
    if (CP0Out !== e) begin errors++; $display("FAIL wrap_cause: got %h want %h", CP0Out, e); end
    EXLClr = 1'b1; cyc(); quiet();
    ExcCodeIn = 5'd6; VPC = 32'h3017; BDIn = 1'b1;
    exp_q.push_back(32'h0000_3010);
    cyc(); quiet();
    e = exp_q.pop_front(); checks++;
    if (EPCOut !== e) begin errors++; $display("FAIL epc_align: got %h want %h", EPCOut, e); end
    EXLClr = 1'b1; cyc(); quiet();
  endtask

  task automatic test_prid();
    en = 1'b1; CP0Add = 5'd15; CP0In = 32'hDEAD_BEEF;
    cyc(); quiet();
`ifdef CP0_PRID_EN
    exp_q.push_back(32'h5052_4944);
`else
    exp_q.push_back(32'h0);
`endif
    exp_q.push_back(32'h0);
    CP0Add = 5'd15; #1; e = exp_q.pop_front(); checks++;
    if (CP0Out !== e) begin errors++; $display("FAIL prid_read: got %h want %h", CP0Out, e); end
    CP0Add = 5'd3; #1; e = exp_q.pop_front(); checks++;
    if (CP0Out !== e) begin errors++; $display("FAIL other_addr: got %h want %h", CP0Out, e); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_exception();
    test_delay_slot();
    test_int_vs_exc();
    test_mtc0_suppressed();
    test_mtc0_latency();
    test_reset_wins();
    test_epc_boundaries();
    test_prid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
